// File: rtl/reg_wb_if.sv
// Writeback bus between two requesters and the register-file write arbiter.
// Define WB_FORWARD_EN to add the read-port forwarding signals.
interface reg_wb_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              a_valid, a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid, b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              wb_stall;
  logic              RegWrite;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;
  logic [CNT_W-1:0]  wr_count;
`ifdef WB_FORWARD_EN
  logic [ADDR_W-1:0] rd_addr_1, rd_addr_2;
  logic              fwd_hit_1, fwd_hit_2;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, wb_stall, rd_addr_1, rd_addr_2,
    input  a_ready, b_ready, RegWrite, write_address, write_data, wr_count,
           fwd_hit_1, fwd_hit_2, fwd_data
  );
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, wb_stall, rd_addr_1, rd_addr_2,
    output a_ready, b_ready, RegWrite, write_address, write_data, wr_count,
           fwd_hit_1, fwd_hit_2, fwd_data
  );
`else
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, wb_stall,
    input  a_ready, b_ready, RegWrite, write_address, write_data, wr_count
  );
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, wb_stall,
    output a_ready, b_ready, RegWrite, write_address, write_data, wr_count
  );
`endif
endinterface

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B).
// Define WB_FORWARD_EN to add combinational bypass from the registered write stage.
module reg_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic   clk,
  input  logic   rst,
  reg_wb_if.slave bus
);
  typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_e;

  ptr_e              ptr_q, ptr_d;
  logic              a_gnt, b_gnt;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Pointer always ends up naming the requester that did not win.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    ptr_d = ptr_q;
    if (!rst && !bus.wb_stall) begin
      if (bus.a_valid && bus.b_valid) begin
        a_gnt = (ptr_q == PTR_A);
        b_gnt = (ptr_q == PTR_B);
        ptr_d = (ptr_q == PTR_A) ? PTR_B : PTR_A;
      end else if (bus.a_valid) begin
        a_gnt = 1'b1;
        ptr_d = PTR_B;
      end else if (bus.b_valid) begin
        b_gnt = 1'b1;
        ptr_d = PTR_A;
      end
    end
  end

  // Register-0 grants complete the handshake but never reach the register file.
  always_comb begin
    gnt_addr = a_gnt ? bus.a_addr : bus.b_addr;
    gnt_data = a_gnt ? bus.a_data : bus.b_data;
    we_d     = (a_gnt || b_gnt) && (gnt_addr != '0);
    addr_d   = we_d ? gnt_addr : addr_q;
    data_d   = we_d ? gnt_data : data_q;
    cnt_d    = (we_d && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= PTR_A;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.a_ready       = a_gnt;
  assign bus.b_ready       = b_gnt;
  assign bus.RegWrite      = we_q;
  assign bus.write_address = addr_q;
  assign bus.write_data    = data_q;
  assign bus.wr_count      = cnt_q;

`ifdef WB_FORWARD_EN
  assign bus.fwd_hit_1 = we_q && (bus.rd_addr_1 == addr_q) && (addr_q != '0);
  assign bus.fwd_hit_2 = we_q && (bus.rd_addr_2 == addr_q) && (addr_q != '0);
  assign bus.fwd_data  = data_q;
`endif
endmodule
